// File: rtl/ebaz_led_pkg.sv
// Shared definitions for the EBAZ status-LED controller: LED modes, command
// byte field positions, and the blink half-period helper.
package ebaz_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_ACT   = 2'b11
  } mode_e;

  localparam int unsigned CMD_W        = 8;
  localparam int unsigned CMD_SEL_BIT  = 7;
  localparam int unsigned CMD_MODE_HI  = 6;
  localparam int unsigned CMD_MODE_LO  = 5;
  localparam int unsigned CMD_PARAM_HI = 4;
  localparam int unsigned CMD_PARAM_LO = 0;
  localparam int unsigned PARAM_W      = 5;
  localparam int unsigned PWM_W        = 5;

  // Ticks per blink half-period per unit of param; 16 * 31 = 496 fits 9 bits.
  localparam int unsigned BLINK_UNIT   = 16;
  localparam int unsigned BLINK_W      = 9;

  // Half-period in ticks; param 0 behaves like param 1.
  function automatic logic [BLINK_W-1:0] blink_half(input logic [PARAM_W-1:0] p);
    logic [PARAM_W-1:0] q;
    q = (p == '0) ? PARAM_W'(1) : p;
    return BLINK_W'(q) * BLINK_W'(BLINK_UNIT);
  endfunction

endpackage

// File: rtl/ebaz_led_if.sv
// Command byte handshake between the PS7 EMIO GPIO side (master) and the
// LED controller (slave).
interface ebaz_led_if;
  import ebaz_led_pkg::*;

  logic [CMD_W-1:0] cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/ebaz_led_chan.sv
// One LED channel: mode/param registers, blink counter and phase, optional
// PWM gating (LED_PWM_EN), and the registered LED level.
module ebaz_led_chan
  import ebaz_led_pkg::*;
(
  input  logic               fclk,
  input  logic               rst,
  input  logic               load,
  input  mode_e              mode_in,
  input  logic [PARAM_W-1:0] param_in,
  input  logic               tick,
  input  logic               stretch_active,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]   pwm_cnt,
`endif
  output logic               level
);

  mode_e              mode;
  logic [PARAM_W-1:0] param;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic               blink_wrap;
  logic               phase_nxt;
  logic               lit_gate;
  logic               level_nxt;

`ifdef LED_PWM_EN
  // Duty gate shared by all lit states; param 0 means always lit.
  always_comb lit_gate = (param == '0) || (pwm_cnt < param);
`else
  // No PWM: lit states are solid.
  always_comb lit_gate = 1'b1;
`endif

  // The output register samples the post-toggle phase so the pin moves one
  // cycle after the counting tick rather than two.
  always_comb begin
    blink_wrap = tick && (mode == MODE_BLINK) &&
                 (blink_cnt == blink_half(param) - BLINK_W'(1));
    phase_nxt  = blink_wrap ? ~phase : phase;
    level_nxt  = 1'b0;
    case (mode)
      MODE_OFF:   level_nxt = 1'b0;
      MODE_ON:    level_nxt = lit_gate;
      MODE_BLINK: level_nxt = phase_nxt && lit_gate;
      MODE_ACT:   level_nxt = stretch_active && lit_gate;
      default:    level_nxt = 1'b0;
    endcase
  end

  // Command load restarts the blink lit phase; otherwise count ticks in blink mode.
  always_ff @(posedge fclk) begin
    if (rst) begin
      mode      <= MODE_OFF;
      param     <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      level     <= 1'b0;
    end else begin
      level <= level_nxt;
      if (load) begin
        mode      <= mode_in;
        param     <= param_in;
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (tick && (mode == MODE_BLINK)) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
        phase     <= phase_nxt;
      end
    end
  end

endmodule

// File: rtl/ebaz_led_ctl.sv
// EBAZ status-LED controller top: tick generator, shared activity pulse
// stretcher, command handshake, two LED channels and pin polarity.
// Optional macro LED_PWM_EN adds a 5-bit free-running PWM counter.
module ebaz_led_ctl
  import ebaz_led_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic             fclk,
  input  logic             rst,
  ebaz_led_if.slave        cmd,
  input  logic             act_in,
  output logic             led_red,
  output logic             led_green
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned STR_W  = $clog2(STRETCH_TICKS + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [STR_W-1:0]  stretch_cnt;
  logic              stretch_active;
  logic              apply_q;
  logic              accept;
  logic              load_red;
  logic              load_green;
  mode_e             cmd_mode;
  logic [PARAM_W-1:0] cmd_param;
  logic              red_level;
  logic              green_level;

  // Ready is combinational on rst so the first accept can land in the very
  // first cycle after reset release; apply_q blocks the cycle after an accept.
  always_comb begin
    cmd.cmd_ready = !rst && !apply_q;
    accept        = cmd.cmd_valid && cmd.cmd_ready;
    load_red      = accept && !cmd.cmd_data[CMD_SEL_BIT];
    load_green    = accept &&  cmd.cmd_data[CMD_SEL_BIT];
    cmd_mode      = mode_e'(cmd.cmd_data[CMD_MODE_HI:CMD_MODE_LO]);
    cmd_param     = cmd.cmd_data[CMD_PARAM_HI:CMD_PARAM_LO];
    tick          = (tick_cnt == TICK_W'(TICK_DIV - 1));
    stretch_active = (stretch_cnt != '0);
  end

  // Apply cycle flag: one dead cycle after each accepted command.
  always_ff @(posedge fclk) begin
    if (rst) apply_q <= 1'b0;
    else     apply_q <= accept;
  end

  // Base tick divider, wraps at TICK_DIV-1.
  always_ff @(posedge fclk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Activity stretcher: a pulse reloads, and takes priority over the expiring tick.
  always_ff @(posedge fclk) begin
    if (rst)
      stretch_cnt <= '0;
    else if (act_in)
      stretch_cnt <= STR_W'(STRETCH_TICKS);
    else if (tick && stretch_active)
      stretch_cnt <= stretch_cnt - STR_W'(1);
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // Free-running PWM phase shared by both channels.
  always_ff @(posedge fclk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_W'(1);
  end
`endif

  ebaz_led_chan u_red (
    .fclk           (fclk),
    .rst            (rst),
    .load           (load_red),
    .mode_in        (cmd_mode),
    .param_in       (cmd_param),
    .tick           (tick),
    .stretch_active (stretch_active),
`ifdef LED_PWM_EN
    .pwm_cnt        (pwm_cnt),
`endif
    .level          (red_level)
  );

  ebaz_led_chan u_green (
    .fclk           (fclk),
    .rst            (rst),
    .load           (load_green),
    .mode_in        (cmd_mode),
    .param_in       (cmd_param),
    .tick           (tick),
    .stretch_active (stretch_active),
`ifdef LED_PWM_EN
    .pwm_cnt        (pwm_cnt),
`endif
    .level          (green_level)
  );

  // Pin polarity applied after the registered channel levels.
  always_comb begin
    led_red   = red_level   ^ ACTIVE_LOW;
    led_green = green_level ^ ACTIVE_LOW;
  end

endmodule

// File: tb/tb_ebaz_led_ctl.sv
// Directed bench for ebaz_led_ctl with TICK_DIV=4, STRETCH_TICKS=8.
// A second instance with ACTIVE_LOW=1 receives identical stimulus.
module tb_ebaz_led_ctl;

  localparam int TD = 4;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  logic act_in = 1'b0;
  logic led_red, led_green, alt_red, alt_green;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ebaz_led_if cmd_if ();
  ebaz_led_if alt_if ();

  ebaz_led_ctl #(.TICK_DIV(4), .STRETCH_TICKS(8), .ACTIVE_LOW(1'b0)) dut (
    .fclk(fclk), .rst(rst), .cmd(cmd_if), .act_in(act_in),
    .led_red(led_red), .led_green(led_green)
  );

  ebaz_led_ctl #(.TICK_DIV(4), .STRETCH_TICKS(8), .ACTIVE_LOW(1'b1)) dut_alt (
    .fclk(fclk), .rst(rst), .cmd(alt_if), .act_in(act_in),
    .led_red(alt_red), .led_green(alt_green)
  );

  always #5 fclk = ~fclk;

  // Cycle index since reset release; ticks fall on cycles with cyc % 4 == 3.
  always @(posedge fclk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 5000 && cyc < t; i++) step();
    if (cyc != t) chk("wait_cyc", cyc, t);
  endtask

  function automatic int nt(input int c);
    int t;
    t = c + 1;
    while ((t % TD) != TD - 1) t++;
    return t;
  endfunction

  task automatic send(input logic [7:0] b, output int n);
    cmd_if.cmd_data  = b;
    alt_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    alt_if.cmd_valid = 1'b1;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_if.cmd_ready) begin
        n = cyc;
        step();
        break;
      end
      step();
    end
    cmd_if.cmd_valid = 1'b0;
    alt_if.cmd_valid = 1'b0;
    if (n < 0) chk("send_acc", cmd_if.cmd_ready, 1'b1);
  endtask

  task automatic pulse();
    act_in = 1'b1;
    step();
    act_in = 1'b0;
  endtask

  initial begin
    int n, n2, t, p, p2, off, old_off, t8, hi;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    alt_if.cmd_valid = 1'b0;
    alt_if.cmd_data  = '0;

    // Reset state
    repeat (3) step();
    #1;
    chk("rst_ready", cmd_if.cmd_ready, 0);
    chk("rst_red", led_red, 0);
    chk("rst_green", led_green, 0);
    chk("rst_alt_red", alt_red, 1);
    chk("rst_alt_green", alt_green, 1);
    rst = 1'b0;
    #1;
    chk("rel_ready", cmd_if.cmd_ready, 1);

    // Handshake: red on
    send(8'h20, n);
    #1;
    chk("hs_ready_low", cmd_if.cmd_ready, 0);
    chk("hs_red_lat", led_red, 0);
    step(); #1;
    chk("hs_ready_back", cmd_if.cmd_ready, 1);
    chk("hs_red_on", led_red, 1);
    chk("hs_green_off", led_green, 0);
    chk("hs_alt_red", alt_red, 0);
    chk("hs_alt_green", alt_green, 1);

`ifndef LED_PWM_EN
    // Blink: green, param 1 -> 16-tick half period
    send(8'hC1, n);
    step(); #1;
    chk("blink_lit", led_green, 1);
    t = nt(n) + 60 + 1;
    wait_cyc(t - 1); #1;
    chk("blink_hold", led_green, 1);
    step(); #1;
    chk("blink_fall", led_green, 0);
    wait_cyc(t + 63); #1;
    chk("blink_dark_end", led_green, 0);
    step(); #1;
    chk("blink_rise", led_green, 1);

    // Re-issue mid dark phase restarts the lit phase
    wait_cyc(t + 138); #1;
    chk("blink_dark", led_green, 0);
    send(8'hC1, n2);
    step(); #1;
    chk("blink_restart", led_green, 1);
    off = nt(n2) + 61;
    wait_cyc(off - 1); #1;
    chk("blink_re_hold", led_green, 1);
    step(); #1;
    chk("blink_re_fall", led_green, 0);
    chk("blink_red_kept", led_red, 1);
`endif

    // Activity: red
    send(8'h60, n);
    step(); #1;
    chk("act_idle", led_red, 0);
    p = cyc;
    pulse();
    step(); #1;
    chk("act_lit", led_red, 1);
    off = nt(p) + 30;
    wait_cyc(off - 1); #1;
    chk("act_hold", led_red, 1);
    step(); #1;
    chk("act_off", led_red, 0);

    // Second pulse at tick 7 extends the indication
    p = cyc + 2;
    wait_cyc(p);
    pulse();
    p2 = nt(p) + 24;
    old_off = nt(p) + 30;
    wait_cyc(p2);
    pulse();
    wait_cyc(old_off); #1;
    chk("act_extend", led_red, 1);
    off = nt(p2) + 30;
    wait_cyc(off - 1); #1;
    chk("act_ext_hold", led_red, 1);
    step(); #1;
    chk("act_ext_off", led_red, 0);

    // Pulse coinciding with the expiring tick keeps it lit
    p = cyc + 2;
    wait_cyc(p);
    pulse();
    t8 = nt(p) + 28;
    wait_cyc(t8);
    pulse();
    wait_cyc(t8 + 2); #1;
    chk("act_coinc", led_red, 1);
    off = nt(t8) + 30;
    wait_cyc(off - 1); #1;
    chk("act_coinc_hold", led_red, 1);
    step(); #1;
    chk("act_coinc_off", led_red, 0);

    // On mode with param 8, then param 0
    send(8'h28, n);
    step();
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (led_red) hi++;
      step();
    end
`ifdef LED_PWM_EN
    chk("pwm_duty8", hi, 8);
`else
    chk("on_solid", hi, 32);
`endif
    send(8'h20, n);
    step();
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (led_red) hi++;
      step();
    end
    chk("on_param0", hi, 32);

    // Reset mid-blink
    send(8'hC1, n);
    repeat (5) step();
    #1;
    chk("rstm_pre", led_green, 1);
    rst = 1'b1;
    #1;
    chk("rstm_ready", cmd_if.cmd_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rstm_red", led_red, 0);
    chk("rstm_green", led_green, 0);
    chk("rstm_ready_back", cmd_if.cmd_ready, 1);
    chk("rstm_alt_red", alt_red, 1);
    chk("rstm_alt_green", alt_green, 1);
    repeat (80) step();
    #1;
    chk("rstm_red_off", led_red, 0);
    chk("rstm_green_off", led_green, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
